// File: rtl/fifo_pack_reader_pkg.sv
// Shared types and helpers for the FIFO pack reader: state encoding and a
// ceiling-log2 used to size the lane counter and the valid-lane count.
package fifo_pack_reader_pkg;

   typedef enum logic {
      S_FILL = 1'b0,
      S_OUT  = 1'b1
   } state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_pack_reader_if.sv
// Bundles the FIFO read port and the wide valid/ready output stream of the pack reader.
// The flush input exists only when FIFO_PACK_READER_FLUSH_EN is defined.
interface fifo_pack_reader_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK       = 4
);
   localparam int CNT_W = fifo_pack_reader_pkg::clog2(PACK + 1);

   logic                       fifo_empty;
   logic [DATA_WIDTH-1:0]      fifo_rdata;
   logic                       fifo_ren;
   logic                       valid;
   logic                       ready;
   logic [DATA_WIDTH*PACK-1:0] data;
   logic [CNT_W-1:0]           count;
`ifdef FIFO_PACK_READER_FLUSH_EN
   logic                       flush;

   modport master (
      input  fifo_empty, fifo_rdata, ready, flush,
      output fifo_ren, valid, data, count
   );
   modport slave (
      output fifo_empty, fifo_rdata, ready, flush,
      input  fifo_ren, valid, data, count
   );
`else
   modport master (
      input  fifo_empty, fifo_rdata, ready,
      output fifo_ren, valid, data, count
   );
   modport slave (
      output fifo_empty, fifo_rdata, ready,
      input  fifo_ren, valid, data, count
   );
`endif

endinterface

// File: rtl/fifo_pack_reader.sv
// Pops PACK words from a synchronous FIFO and emits them as one wide beat (first word in LSBs).
// Optional partial-beat flush is compiled in with FIFO_PACK_READER_FLUSH_EN.
//
// state  | meaning
// S_FILL | popping FIFO words into lanes while the FIFO is non-empty
// S_OUT  | holding a packed beat on the stream until downstream accepts it
module fifo_pack_reader
   import fifo_pack_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PACK       = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   fifo_pack_reader_if.master bus
);

   localparam int CW    = clog2(PACK);
   localparam int CNT_W = clog2(PACK + 1);
   localparam logic [CW-1:0]    LAST_LANE = CW'(PACK - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(PACK);

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0] lane_q [PACK];
   logic [DATA_WIDTH-1:0] lane_d [PACK];
   logic                  pop;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      count_d = count_q;
      lane_d  = lane_q;
      pop     = 1'b0;
      case (state_q)
         S_FILL: begin
            pop = !bus.fifo_empty && !i_reset;
            if (pop) begin
               lane_d[cnt_q] = bus.fifo_rdata;
               if (cnt_q == LAST_LANE) begin
                  state_d = S_OUT;
                  count_d = FULL_CNT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
`ifdef FIFO_PACK_READER_FLUSH_EN
            // A same-cycle pop is folded into the partial beat; a pop completing the beat wins.
            if (bus.flush && !(pop && cnt_q == LAST_LANE) && (cnt_q != '0 || pop)) begin
               state_d = S_OUT;
               count_d = CNT_W'(cnt_q) + CNT_W'(pop);
               cnt_d   = '0;
            end
`endif
         end
         S_OUT: begin
            if (bus.ready) begin
               state_d = S_FILL;
               count_d = '0;
               for (int k = 0; k < PACK; k++) lane_d[k] = '0;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   always_comb begin
      bus.fifo_ren = pop;
      bus.valid    = (state_q == S_OUT);
      bus.count    = count_q;
      bus.data     = '0;
      for (int k = 0; k < PACK; k++) bus.data[k*DATA_WIDTH +: DATA_WIDTH] = lane_q[k];
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= S_FILL;
         cnt_q   <= '0;
         count_q <= '0;
         for (int k = 0; k < PACK; k++) lane_q[k] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
         lane_q  <= lane_d;
      end
   end

endmodule
